jzjpcc_mem_port_arbiter: RTL and testbench
==========================================

JZJPCC_MEM_PORT_ARBITER -- requirements
Module: jzjpcc_mem_port_arbiter

Interface
REQ-001 Parameter PC_MAX_B, default 11, index of the most significant word-address bit of the single-port SRAM.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 fetchAddress  input  [PC_MAX_B:2]  next-PC word address from the fetch stage.
REQ-005 dataReq  input  1  memory-stage request, level, held until dataAck.
REQ-006 dataWriteEnable  input  1  1 = store, 0 = load; valid while dataReq.
REQ-007 dataAddress  input  [PC_MAX_B:2]  load/store word address.
REQ-008 dataWriteData  input  32  store data; dataByteEnable  input  4  store byte lanes.
REQ-009 dataReadData  output  32  load result; dataAck  output  1  one-cycle transaction-complete pulse.
REQ-010 sramAddress  output  [PC_MAX_B:2]; sramWriteEnable  output  1; sramByteEnable  output  4; sramWriteData  output  32; sramReadData  input  32 (SRAM registers its address, one-cycle read latency).
REQ-011 stall_fetch  output  1  holds the PC; flush_decode  output  1  forces a nop into decode.
REQ-012 stallCycleCount  output  32  count of cycles with stall_fetch high.

Function
REQ-013 FSM states FETCH, ISSUE, RESP, held in a registered state variable.
REQ-014 FETCH: sramAddress = fetchAddress, sramWriteEnable = 0, stall_fetch = 0, flush_decode = 0, dataAck = 0.
REQ-015 FETCH with dataReq = 1: dataWriteEnable, dataAddress, dataWriteData and dataByteEnable are latched at the edge; next state ISSUE.
REQ-016 ISSUE lasts exactly one cycle: sramAddress = latched address, sramWriteEnable = latched write flag, sramByteEnable/sramWriteData from the latched values, stall_fetch = 1; next state RESP.
REQ-017 RESP lasts exactly one cycle: sramAddress = fetchAddress (replay of the held PC), sramWriteEnable = 0, flush_decode = 1, dataAck = 1, stall_fetch = 0; next state FETCH.
REQ-018 In RESP of a load, dataReadData = sramReadData; for a store, dataReadData is don't-care.
REQ-019 Requests are accepted only in FETCH; dataReq seen in ISSUE or RESP never starts a new transaction, so at least one FETCH cycle separates transactions.
REQ-020 Latency: request accepted at edge N, dataAck high in the cycle after edge N+1 (two cycles from request-visible to ack).
REQ-021 Changes on data inputs after acceptance have no effect on the in-flight transaction.
REQ-022 stallCycleCount increments by 1 on every edge where stall_fetch = 1, wraps from 32'hFFFFFFFF to 0.
REQ-023 fetchAddress passes combinationally to sramAddress in FETCH and RESP; no other combinational input-to-output paths except sramReadData to dataReadData.

Reset
REQ-024 reset = 1 at an edge forces state FETCH, clears latched request, stallCycleCount = 0, read-data register = 0.
REQ-025 Reset in ISSUE or RESP abandons the transaction: no dataAck is produced afterward.
REQ-026 Outputs while in FETCH after reset: stall_fetch = 0, flush_decode = 0, dataAck = 0, sramWriteEnable = 0.

Configuration
REQ-027 Macro JZJPCC_ARB_READ_HOLD_EN: when defined, the RESP load data is captured in a 32-bit register and dataReadData presents that register, stable until the next load's RESP cycle (in RESP itself dataReadData = sramReadData).
REQ-028 Without JZJPCC_ARB_READ_HOLD_EN, no register exists and dataReadData = sramReadData in all states (valid only in RESP).

Verification
REQ-029 Reset, then 3 idle cycles with fetchAddress = 0x10 -> sramAddress = 0x10, stall_fetch = 0, flush_decode = 0, stallCycleCount = 0.
REQ-030 Load dataAddress = 0x40, sramReadData = 32'hDEADBEEF in RESP -> ISSUE: sramAddress = 0x40, stall_fetch = 1; RESP: dataAck = 1, dataReadData = 32'hDEADBEEF, flush_decode = 1, sramAddress = fetchAddress; stallCycleCount = 1.
REQ-031 Store dataAddress = 0x08, data 32'h12345678, byte enable 4'b0011 -> exactly one ISSUE cycle with sramWriteEnable = 1, sramByteEnable = 4'b0011, sramWriteData = 32'h12345678; dataAck in following cycle.
REQ-032 dataReq held high continuously for two transactions -> ack pulses separated by exactly one FETCH cycle (ISSUE, RESP, FETCH, ISSUE, RESP); stallCycleCount = 2.
REQ-033 reset asserted during ISSUE -> next cycle FETCH, dataAck never asserts, stallCycleCount = 0.
REQ-034 With JZJPCC_ARB_READ_HOLD_EN, load returns 32'hCAFEF00D then sramReadData changes -> dataReadData stays 32'hCAFEF00D until next load's RESP.

Source files
------------

// File: rtl/jzjpcc_mem_port_arbiter.sv
// Single-port SRAM arbiter: fetch owns the port except for a two-cycle ISSUE/RESP data slot.
// Optional JZJPCC_ARB_READ_HOLD_EN keeps the last load result stable outside RESP.
module jzjpcc_mem_port_arbiter #(
  parameter int unsigned PC_MAX_B = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [PC_MAX_B:2] fetchAddress,
  input  logic              dataReq,
  input  logic              dataWriteEnable,
  input  logic [PC_MAX_B:2] dataAddress,
  input  logic [31:0]       dataWriteData,
  input  logic [3:0]        dataByteEnable,
  output logic [31:0]       dataReadData,
  output logic              dataAck,
  output logic [PC_MAX_B:2] sramAddress,
  output logic              sramWriteEnable,
  output logic [3:0]        sramByteEnable,
  output logic [31:0]       sramWriteData,
  input  logic [31:0]       sramReadData,
  output logic              stall_fetch,
  output logic              flush_decode,
  output logic [31:0]       stallCycleCount
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_we;
  logic [PC_MAX_B:2] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic [31:0]       r_stall_cnt;

  always_ff @(posedge clock) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next_state;
  end

  // New requests are only taken while fetch owns the port.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FETCH:   if (dataReq) w_next_state = ISSUE;
      ISSUE:   w_next_state = RESP;
      RESP:    w_next_state = FETCH;
      default: w_next_state = FETCH;
    endcase
  end

  // RESP replays the held PC so the instruction stalled during ISSUE is refetched.
  always_comb begin
    sramAddress     = fetchAddress;
    sramWriteEnable = 1'b0;
    stall_fetch     = 1'b0;
    flush_decode    = 1'b0;
    dataAck         = 1'b0;
    case (r_state)
      ISSUE: begin
        sramAddress     = r_addr;
        sramWriteEnable = r_we;
        stall_fetch     = 1'b1;
      end
      RESP: begin
        flush_decode = 1'b1;
        dataAck      = 1'b1;
      end
      default: ;
    endcase
  end

  // Request snapshot isolates the in-flight transaction from later input changes.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
    end else if (r_state == FETCH && dataReq) begin
      r_we    <= dataWriteEnable;
      r_addr  <= dataAddress;
      r_wdata <= dataWriteData;
      r_be    <= dataByteEnable;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)                 r_stall_cnt <= 32'd0;
    else if (r_state == ISSUE) r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign sramByteEnable  = r_be;
  assign sramWriteData   = r_wdata;
  assign stallCycleCount = r_stall_cnt;

`ifdef JZJPCC_ARB_READ_HOLD_EN
  logic [31:0] r_rdata;

  always_ff @(posedge clock) begin
    if (reset)                         r_rdata <= 32'd0;
    else if (r_state == RESP && !r_we) r_rdata <= sramReadData;
  end

  assign dataReadData = (r_state == RESP) ? sramReadData : r_rdata;
`else
  assign dataReadData = sramReadData;
`endif

endmodule

// File: tb/tb_jzjpcc_mem_port_arbiter.sv
// Randomized and directed bench for jzjpcc_mem_port_arbiter against a cycle-arithmetic model.
module tb_jzjpcc_mem_port_arbiter;
  localparam int unsigned PC_MAX_B = 11;
  localparam int unsigned AW = PC_MAX_B - 1;

  logic              clock = 1'b0;
  logic              reset;
  logic [PC_MAX_B:2] fetchAddress, dataAddress, sramAddress;
  logic              dataReq, dataWriteEnable, dataAck, sramWriteEnable;
  logic [31:0]       dataWriteData, dataReadData, sramWriteData, sramReadData, stallCycleCount;
  logic [3:0]        dataByteEnable, sramByteEnable;
  logic              stall_fetch, flush_decode;

  jzjpcc_mem_port_arbiter #(.PC_MAX_B(PC_MAX_B)) dut (
    .clock(clock), .reset(reset), .fetchAddress(fetchAddress), .dataReq(dataReq),
    .dataWriteEnable(dataWriteEnable), .dataAddress(dataAddress), .dataWriteData(dataWriteData),
    .dataByteEnable(dataByteEnable), .dataReadData(dataReadData), .dataAck(dataAck),
    .sramAddress(sramAddress), .sramWriteEnable(sramWriteEnable), .sramByteEnable(sramByteEnable),
    .sramWriteData(sramWriteData), .sramReadData(sramReadData), .stall_fetch(stall_fetch),
    .flush_decode(flush_decode), .stallCycleCount(stallCycleCount)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Model: a request accepted at edge E occupies cycle E (issue) and cycle E+1 (response).
  int                cyc = 0;
  int                acc_edge = -100;
  logic              m_we;
  logic [PC_MAX_B:2] m_addr;
  logic [31:0]       m_wdata, m_cnt, m_hold;
  logic [3:0]        m_be;

  logic              e_stall, e_flush, e_ack, e_swe, e_rchk;
  logic [PC_MAX_B:2] e_saddr;
  logic [31:0]       e_rdata;
  int                e_phase;

  function automatic int phase_of(input int c);
    if (acc_edge >= 0 && c == acc_edge)     return 1;
    if (acc_edge >= 0 && c == acc_edge + 1) return 2;
    return 0;
  endfunction

  task automatic step(input logic rst, input logic req, input logic we,
                      input logic [PC_MAX_B:2] da, input logic [31:0] wd, input logic [3:0] be,
                      input logic [PC_MAX_B:2] fa, input logic [31:0] rd);
    int p;
    @(posedge clock);
    p = phase_of(cyc);
    if (reset) begin
      acc_edge = -100;
      m_cnt    = 32'd0;
      m_hold   = 32'd0;
    end else begin
      if (p == 1) m_cnt = m_cnt + 32'd1;
      if (p == 2 && !m_we) m_hold = sramReadData;
      if (p == 0 && dataReq) begin
        acc_edge = cyc + 1;
        m_we     = dataWriteEnable;
        m_addr   = dataAddress;
        m_wdata  = dataWriteData;
        m_be     = dataByteEnable;
      end
    end
    cyc = cyc + 1;
    #1;
    reset = rst; dataReq = req; dataWriteEnable = we; dataAddress = da;
    dataWriteData = wd; dataByteEnable = be; fetchAddress = fa; sramReadData = rd;
    #1;
    p       = phase_of(cyc);
    e_phase = p;
    e_stall = (p == 1);
    e_flush = (p == 2);
    e_ack   = (p == 2);
    e_swe   = (p == 1) && m_we;
    e_saddr = (p == 1) ? m_addr : fetchAddress;
`ifdef JZJPCC_ARB_READ_HOLD_EN
    e_rchk  = (p == 2) ? !m_we : 1'b1;
    e_rdata = (p == 2) ? sramReadData : m_hold;
`else
    e_rchk  = (p == 2) ? !m_we : 1'b1;
    e_rdata = sramReadData;
`endif
  endtask

  task automatic idle(input logic [PC_MAX_B:2] fa);
    step(1'b0, 1'b0, 1'b0, '0, 32'd0, 4'd0, fa, $urandom());
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, '0, 32'd0, 4'd0, AW'(16), 32'd0);
    for (int i = 0; i < 3; i++) begin
      idle(AW'(16));
      total++; if (sramAddress !== AW'(16)) begin bad++; $display("FAIL rst_addr got=%h exp=%h", sramAddress, AW'(16)); end
      total++; if (stall_fetch !== 1'b0 || flush_decode !== 1'b0 || dataAck !== 1'b0 || sramWriteEnable !== 1'b0) begin
        bad++; $display("FAIL rst_ctrl got stall=%b flush=%b ack=%b we=%b exp all 0", stall_fetch, flush_decode, dataAck, sramWriteEnable); end
      total++; if (stallCycleCount !== 32'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", stallCycleCount); end
    end
  endtask

  task automatic test_load();
    step(1'b0, 1'b1, 1'b0, AW'(64), 32'h0, 4'hF, AW'(20), 32'h0);
    total++; if (dataAck !== 1'b0) begin bad++; $display("FAIL ld_fetch_ack got=%b exp=0", dataAck); end
    step(1'b0, 1'b1, 1'b1, AW'($urandom()), $urandom(), 4'h5, AW'(20), 32'h0);
    total++; if (sramAddress !== AW'(64)) begin bad++; $display("FAIL ld_issue_addr got=%h exp=%h", sramAddress, AW'(64)); end
    total++; if (stall_fetch !== 1'b1 || sramWriteEnable !== 1'b0) begin bad++; $display("FAIL ld_issue_ctrl got stall=%b we=%b exp 1 0", stall_fetch, sramWriteEnable); end
    step(1'b0, 1'b1, 1'b0, AW'(64), 32'h0, 4'hF, AW'(20), 32'hDEADBEEF);
    total++; if (dataAck !== 1'b1 || flush_decode !== 1'b1 || stall_fetch !== 1'b0) begin
      bad++; $display("FAIL ld_resp_ctrl got ack=%b flush=%b stall=%b exp 1 1 0", dataAck, flush_decode, stall_fetch); end
    total++; if (dataReadData !== 32'hDEADBEEF) begin bad++; $display("FAIL ld_rdata got=%h exp=deadbeef", dataReadData); end
    total++; if (sramAddress !== AW'(20)) begin bad++; $display("FAIL ld_resp_addr got=%h exp=%h", sramAddress, AW'(20)); end
    idle(AW'(21));
    total++; if (stallCycleCount !== 32'd1) begin bad++; $display("FAIL ld_cnt got=%0d exp=1", stallCycleCount); end
  endtask

  task automatic test_store();
    step(1'b0, 1'b1, 1'b1, AW'(8), 32'h12345678, 4'b0011, AW'(30), 32'h0);
    step(1'b0, 1'b1, 1'b0, AW'(99), 32'hFFFFFFFF, 4'b1100, AW'(30), 32'h0);
    total++; if (sramWriteEnable !== 1'b1 || sramByteEnable !== 4'b0011) begin
      bad++; $display("FAIL st_issue got we=%b be=%b exp 1 0011", sramWriteEnable, sramByteEnable); end
    total++; if (sramWriteData !== 32'h12345678 || sramAddress !== AW'(8)) begin
      bad++; $display("FAIL st_issue_data got wd=%h addr=%h exp 12345678 %h", sramWriteData, sramAddress, AW'(8)); end
    step(1'b0, 1'b1, 1'b1, AW'(8), 32'h12345678, 4'b0011, AW'(30), 32'h0);
    total++; if (dataAck !== 1'b1 || sramWriteEnable !== 1'b0) begin bad++; $display("FAIL st_resp got ack=%b we=%b exp 1 0", dataAck, sramWriteEnable); end
    idle(AW'(31));
    total++; if (stall_fetch !== 1'b0 || dataAck !== 1'b0) begin bad++; $display("FAIL st_after got stall=%b ack=%b exp 0 0", stall_fetch, dataAck); end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ack_pat   = 6'b100100;
    logic [5:0]  stall_pat = 6'b010010;
    logic [31:0] c0        = stallCycleCount;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b0, AW'(i), 32'h0, 4'hF, AW'(40), $urandom());
      total++; if (dataAck !== ack_pat[i] || stall_fetch !== stall_pat[i]) begin
        bad++; $display("FAIL b2b_c%0d got ack=%b stall=%b exp %b %b", i, dataAck, stall_fetch, ack_pat[i], stall_pat[i]); end
    end
    idle(AW'(41));
    total++; if (stallCycleCount - c0 !== 32'd2) begin bad++; $display("FAIL b2b_cnt got=%0d exp=2", stallCycleCount - c0); end
  endtask

  task automatic test_reset_in_issue();
    step(1'b0, 1'b1, 1'b0, AW'(12), 32'h0, 4'hF, AW'(50), 32'h0);
    step(1'b1, 1'b1, 1'b0, AW'(12), 32'h0, 4'hF, AW'(50), 32'h0);
    total++; if (stall_fetch !== 1'b1) begin bad++; $display("FAIL rsti_issue got stall=%b exp 1", stall_fetch); end
    for (int i = 0; i < 3; i++) begin
      idle(AW'(50));
      total++; if (dataAck !== 1'b0 || stall_fetch !== 1'b0 || stallCycleCount !== 32'd0) begin
        bad++; $display("FAIL rsti_c%0d got ack=%b stall=%b cnt=%0d exp 0 0 0", i, dataAck, stall_fetch, stallCycleCount); end
    end
  endtask

  task automatic test_read_data();
`ifdef JZJPCC_ARB_READ_HOLD_EN
    step(1'b0, 1'b1, 1'b0, AW'(3), 32'h0, 4'hF, AW'(60), 32'h0);
    step(1'b0, 1'b1, 1'b0, AW'(3), 32'h0, 4'hF, AW'(60), 32'h0);
    step(1'b0, 1'b1, 1'b0, AW'(3), 32'h0, 4'hF, AW'(60), 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) begin
      idle(AW'(61));
      total++; if (dataReadData !== 32'hCAFEF00D) begin bad++; $display("FAIL hold_c%0d got=%h exp=cafef00d", i, dataReadData); end
    end
`else
    for (int i = 0; i < 3; i++) begin
      idle(AW'(61));
      total++; if (dataReadData !== sramReadData) begin bad++; $display("FAIL pass_c%0d got=%h exp=%h", i, dataReadData, sramReadData); end
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(39) == 0), ($urandom_range(2) != 0), 1'($urandom()), AW'($urandom()),
           $urandom(), 4'($urandom()), AW'($urandom()), $urandom());
      total++; if (sramAddress !== e_saddr || sramWriteEnable !== e_swe) begin
        bad++; $display("FAIL rnd_port c%0d got addr=%h we=%b exp %h %b", cyc, sramAddress, sramWriteEnable, e_saddr, e_swe); end
      total++; if (stall_fetch !== e_stall || flush_decode !== e_flush || dataAck !== e_ack) begin
        bad++; $display("FAIL rnd_ctrl c%0d got %b%b%b exp %b%b%b", cyc, stall_fetch, flush_decode, dataAck, e_stall, e_flush, e_ack); end
      total++; if (stallCycleCount !== m_cnt) begin bad++; $display("FAIL rnd_cnt c%0d got=%0d exp=%0d", cyc, stallCycleCount, m_cnt); end
      if (e_rchk) begin
        total++; if (dataReadData !== e_rdata) begin bad++; $display("FAIL rnd_rdata c%0d got=%h exp=%h", cyc, dataReadData, e_rdata); end
      end
      if (e_phase == 1) begin
        total++; if (sramByteEnable !== m_be || sramWriteData !== m_wdata) begin
          bad++; $display("FAIL rnd_issue c%0d got be=%b wd=%h exp %b %h", cyc, sramByteEnable, sramWriteData, m_be, m_wdata); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; dataReq = 1'b0; dataWriteEnable = 1'b0; dataAddress = '0;
    dataWriteData = 32'd0; dataByteEnable = 4'd0; fetchAddress = '0; sramReadData = 32'd0;
    m_we = 1'b0; m_addr = '0; m_wdata = 32'd0; m_be = 4'd0; m_cnt = 32'd0; m_hold = 32'd0;
    test_reset();
    test_load();
    test_store();
    test_back_to_back();
    test_reset_in_issue();
    test_read_data();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
